// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory initiator slice.
// The RMW states exist only when MEM_INIT_RMW_EN is defined.
package mem_if_pkg;

    localparam int WORD_W         = 32;
    localparam int BE_W           = 4;
    localparam int DEFAULT_ADDR_W = 30;

`ifdef MEM_INIT_RMW_EN
    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, RMW_RD, RMW_MERGE, WR
    } mem_init_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR
    } mem_init_state_t;
`endif

endpackage

// File: rtl/mem_initiator_if.sv
// CPU-side request/response handshake plus the word-addressed responder strobes.
// master = the initiator, slave = whoever drives requests and models the responder.
interface mem_initiator_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              mem_rren;
    logic              mem_e;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
               mem_addr, mem_wdata, mem_wren, mem_rren, mem_e
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_addr, mem_wdata, mem_wren, mem_rren, mem_e
    );

endinterface

// File: rtl/mem_byte_merge.sv
// Byte-lane merge for partial stores: enabled lanes take the new word,
// the rest keep the word read back from memory.
module mem_byte_merge
    import mem_if_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_word,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] merged
);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator for a one-cycle-latency word memory.
// Define MEM_INIT_RMW_EN to enable read-modify-write for partial-mask stores.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic           clk,
    input  logic           rst,
    mem_initiator_if.master bus
);

    mem_init_state_t state, state_n;
    logic            hs;
    logic            rsp_n, rd_n, wr_n;

    assign hs = bus.req_valid && bus.req_ready;

`ifdef MEM_INIT_RMW_EN
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] merged;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // mem_wdata already holds the store data here, so it doubles as the new word
    mem_byte_merge u_merge (
        .old_word (bus.mem_rdata),
        .new_word (bus.mem_wdata),
        .be       (be_q),
        .merged   (merged)
    );
`else
    logic unused_req_bits;

    assign unused_req_bits = ^{bus.req_addr[1:0], bus.req_be};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        rsp_n   = 1'b0;
        case (state)
            IDLE: if (hs) begin
                if (!bus.req_we)        state_n = RD;
`ifdef MEM_INIT_RMW_EN
                else if (&bus.req_be)   state_n = WR;
                else if (|bus.req_be)   state_n = RMW_RD;
                else                    rsp_n   = 1'b1;
`else
                else                    state_n = WR;
`endif
            end
            RD:        state_n = RD_WAIT;
            RD_WAIT: begin
                state_n = IDLE;
                rsp_n   = 1'b1;
            end
`ifdef MEM_INIT_RMW_EN
            RMW_RD:    state_n = RMW_MERGE;
            RMW_MERGE: state_n = WR;
`endif
            WR: begin
                state_n = IDLE;
                rsp_n   = 1'b1;
            end
            default:   state_n = IDLE;
        endcase

        // strobes are registered, so they follow the state being entered
        rd_n = (state_n == RD);
`ifdef MEM_INIT_RMW_EN
        rd_n = rd_n || (state_n == RMW_RD);
`endif
        wr_n = (state_n == WR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wren  <= 1'b0;
            bus.mem_rren  <= 1'b0;
            bus.mem_e     <= 1'b0;
`ifdef MEM_INIT_RMW_EN
            be_q          <= '0;
`endif
        end else begin
            bus.req_ready <= (state_n == IDLE);
            bus.rsp_valid <= rsp_n;
            bus.mem_rren  <= rd_n;
            bus.mem_wren  <= wr_n;
            bus.mem_e     <= rd_n || wr_n;
            if (hs) begin
                bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
                if (bus.req_we) bus.mem_wdata <= bus.req_wdata;
            end
            if (state == RD_WAIT) bus.rsp_rdata <= bus.mem_rdata;
`ifdef MEM_INIT_RMW_EN
            if (hs)                 be_q          <= bus.req_be;
            if (state == RMW_MERGE) bus.mem_wdata <= merged;
`endif
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed + randomized bench for mem_initiator against a word-array reference
// model; the responder is modelled as a registered-read RAM on the same clock.
module tb_mem_initiator;

    localparam int AW        = 30;
    localparam int MEM_WORDS = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mem_initiator_if #(.ADDR_W(AW)) bus ();

    mem_initiator #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // responder: unconditional registered read, write when E && wren
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr[11:0]];
        if (bus.mem_e && bus.mem_wren) mem[bus.mem_addr[11:0]] = bus.mem_wdata;
    end

    int cyc = 0;
    int acc_q[$];
    int rsp_q[$];
    int wren_cnt = 0;
    int rren_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (bus.rsp_valid)                  rsp_q.push_back(cyc);
        if (bus.mem_wren)                   wren_cnt++;
        if (bus.mem_rren)                   rren_cnt++;
        if (bus.mem_wren && bus.mem_rren)   both_cnt++;
    end

    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // response latency in cycles after the handshake cycle
    function automatic int exp_lat(input logic we, input logic [3:0] be);
        if (!we) return 3;
`ifdef MEM_INIT_RMW_EN
        if (be == 4'h0) return 1;
        if (be == 4'hf) return 2;
        return 4;
`else
        return 2;
`endif
    endfunction

    function automatic int exp_writes(input logic we, input logic [3:0] be);
        if (!we) return 0;
`ifdef MEM_INIT_RMW_EN
        if (be == 4'h0) return 0;
`endif
        return 1;
    endfunction

    function automatic int exp_reads(input logic we, input logic [3:0] be);
        if (!we) return 1;
`ifdef MEM_INIT_RMW_EN
        if (be != 4'h0 && be != 4'hf) return 1;
`endif
        return 0;
    endfunction

    task automatic ref_store(input logic [11:0] w, input logic [31:0] d, input logic [3:0] be);
`ifdef MEM_INIT_RMW_EN
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
`else
        ref_mem[w] = d;
`endif
    endtask

    // one request; entered and left just after a rising edge
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input string tag);
        logic [11:0] w;
        int n, w0, r0, lat;
        w  = addr[13:2];
        w0 = wren_cnt;
        r0 = rren_cnt;
        acc_q.delete();
        rsp_q.delete();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        n = 0;
        @(negedge clk); #1;
        while (acc_q.size() == 0 && n < 10) begin @(negedge clk); #1; n++; end
        if (acc_q.size() == 0) begin
            check({tag, " accept"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() == 0 && n < 12) begin @(negedge clk); #1; n++; end
        lat = (rsp_q.size() == 0) ? -1 : rsp_q[0] - acc_q[0];
        check({tag, " latency"}, lat, exp_lat(we, be));
        if (!we) last_rd = ref_mem[w];
        else     ref_store(w, wdata, be);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, last_rd);
        check({tag, " write strobes"}, wren_cnt - w0, exp_writes(we, be));
        check({tag, " read strobes"}, rren_cnt - r0, exp_reads(we, be));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;
        int n, mism;
        logic [11:0] w;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0]     = 32'h2008_2000; ref_mem[0]     = 32'h2008_2000;
        mem[12'h810] = 32'h11;      ref_mem[12'h810] = 32'h11;
        mem[12'h800] = 32'h40;      ref_mem[12'h800] = 32'h40;

        // reset state
        #2;
        check("rst req_ready", bus.req_ready, 0);
        check("rst rsp_valid", bus.rsp_valid, 0);
        check("rst rsp_rdata", bus.rsp_rdata, 0);
        check("rst mem_addr",  bus.mem_addr, 0);
        check("rst mem_wdata", bus.mem_wdata, 0);
        check("rst strobes",   {bus.mem_e, bus.mem_wren, bus.mem_rren}, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready after release", bus.req_ready, 1);

        // directed loads and stores
        xact(1'b0, 32'h2040, 32'h0, 4'h0, "load 0x2040");
        check("load 0x2040 value", bus.rsp_rdata, 32'h11);
        xact(1'b0, 32'h0000, 32'h0, 4'h0, "load 0x0");
        check("load 0x0 value", bus.rsp_rdata, 32'h2008_2000);
        xact(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hf, "full store");
        xact(1'b0, 32'h2004, 32'h0, 4'h0, "reload 0x2004");
        check("reload 0x2004 value", bus.rsp_rdata, 32'hDEAD_BEEF);
        xact(1'b1, 32'h2000, 32'hAABB_CCDD, 4'h3, "partial store");
        xact(1'b0, 32'h2000, 32'h0, 4'h0, "reload 0x2000");
`ifdef MEM_INIT_RMW_EN
        check("partial merge value", bus.rsp_rdata, 32'h0000_CCDD);
`else
        check("partial merge value", bus.rsp_rdata, 32'hAABB_CCDD);
`endif
        xact(1'b1, 32'h0000, 32'h1234_5678, 4'h0, "empty-mask store");
        xact(1'b0, 32'h0003, 32'h0, 4'h0, "reload 0x0");

        // back-to-back loads with req_valid held high
        acc_q.delete();
        rsp_q.delete();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h2040;
        n = 0;
        while (acc_q.size() < 3 && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < 3 && n < 20) begin @(negedge clk); #1; n++; end
        check("b2b accepts", acc_q.size(), 3);
        check("b2b responses", rsp_q.size(), 3);
        if (acc_q.size() == 3 && rsp_q.size() == 3) begin
            check("b2b accept spacing", {acc_q[1] - acc_q[0], acc_q[2] - acc_q[0]}, {32'd3, 32'd6});
            check("b2b rsp timing", {rsp_q[0] - acc_q[0], rsp_q[1] - acc_q[0], rsp_q[2] - acc_q[0]},
                  {32'd3, 32'd6, 32'd9});
        end
        last_rd = ref_mem[12'h810];
        check("b2b rdata", bus.rsp_rdata, last_rd);
        @(posedge clk); #1;

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, MEM_WORDS - 1) << 2) | ($urandom & 32'h3);
            d = $urandom;
            case ($urandom_range(0, 5))
                0:       be = 4'h0;
                1:       be = 4'hf;
                default: be = 4'($urandom);
            endcase
            xact(1'($urandom), a, d, be, "random");
        end

        // reset in the middle of a store
        w = 12'h123;
        n = wren_cnt;
        acc_q.delete();
        rsp_q.delete();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = {18'h0, w, 2'b00};
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_be    = 4'h6;
        mism = 0;
        while (acc_q.size() == 0 && mism < 10) begin @(negedge clk); #1; mism++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
`ifdef MEM_INIT_RMW_EN
        @(posedge clk); #1;
`endif
        #1 rst = 1'b0;
        #1;
        check("abort strobes", {bus.mem_e, bus.mem_wren, bus.mem_rren}, 0);
        check("abort ready", bus.req_ready, 0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort ready after release", bus.req_ready, 1);
        check("abort no response", rsp_q.size(), 0);
        check("abort no write", wren_cnt - n, 0);
        check("abort mem word", mem[w], ref_mem[w]);
        last_rd = '0;
        check("abort rsp_rdata", bus.rsp_rdata, last_rd);
        xact(1'b0, {18'h0, w, 2'b00}, 32'h0, 4'h0, "load after abort");

        // final memory image and strobe exclusivity
        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("memory image", mism, 0);
        check("wren with rren", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Single-outstanding memory initiator between the CPU load/store path and the word-addressed memory responder. It accepts byte-addressed load and store requests over a valid/ready handshake. It drives the responder's `addr_in`/`data_in`/`mem_wren`/`mem_rren`/`E` strobes, accounts for the responder's one-cycle registered read latency, and performs read-modify-write for partial-word stores. It returns one response pulse per request.

## Interface
Parameters:
- `ADDR_W`, default 30: word-address width driven to the memory.
- `DATA_W`, default 32: word width; must be 32, with 4 byte lanes.

Ports:
- `clk`  in  1  sole clock; the memory responder samples on this same edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W+2  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  store data, lane-aligned.
- `req_be`  in  4  store byte enables; ignored for loads.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  load data; holds its last value otherwise.
- `mem_addr`  out  ADDR_W  connected to responder `addr_in`.
- `mem_wdata`  out  32  connected to responder `data_in`.
- `mem_wren`, `mem_rren`, `mem_e`  out  1  connected to responder `mem_wren`, `mem_rren`, `E`.
- `mem_rdata`  in  32  responder `out`; valid the cycle after a sampled read.

## Operation
- FSM states: IDLE, RD, RD_WAIT, RMW_RD, RMW_MERGE, WR.
- All outputs are registered.
- IDLE, on handshake:
  - load → RD.
  - store with `be=1111` → WR.
  - store with `be=0000` → stays IDLE; `rsp_valid` is pulsed next cycle and no memory strobes are driven.
  - any other store → RMW_RD.
- The request is captured on the handshake. `mem_addr = req_addr[ADDR_W+1:2]`.
- RD: `mem_e=1`, `mem_rren=1` → RD_WAIT.
- RD_WAIT: strobes low; `mem_rdata` is captured into `rsp_rdata` → IDLE with `rsp_valid` pulsed.
- RMW_RD: same strobes as RD → RMW_MERGE.
- RMW_MERGE: merged word is registered; lane i takes `req_wdata` if `be[i]`, else `mem_rdata` → WR.
- WR: `mem_e=1`, `mem_wren=1`, `mem_wdata` = full or merged word → IDLE with `rsp_valid` pulsed.
- `mem_wren` and `mem_rren` are never high together.
- In IDLE, `mem_e=0`. The responder's unconditional read is harmless.
- Stores leave `rsp_rdata` unchanged.
- Reset values:
  - state = IDLE.
  - `req_ready=0` in the reset cycle, 1 from the first cycle after release.
  - `rsp_valid=0`, `rsp_rdata=0`, `mem_addr=0`, `mem_wdata=0`.
  - `mem_wren=0`, `mem_rren=0`, `mem_e=0`.
- Reset mid-operation aborts the transaction:
  - Strobes drop asynchronously.
  - No response is issued.
  - An aborted RMW never writes.

## Timing
Handshake in cycle T.
- Load:
  - Read strobes in T+1.
  - Data captured at the end of T+2.
  - `rsp_valid` in T+3.
  - `req_ready` high again in T+3.
- Full store: write strobe in T+1; `rsp_valid` and ready in T+2.
- Partial store: read in T+1, merge in T+2, write in T+3; `rsp_valid` in T+4.
- Empty-mask store: `rsp_valid` in T+1.
- A new request may be accepted in the same cycle `rsp_valid` is high.

## Configuration
- `MEM_INIT_RMW_EN` defined: partial-mask stores use the RMW path; RMW_RD and RMW_MERGE exist.
- Not defined:
  - `req_be` is ignored and every store is a full-word write (T+1 write, T+2 response).
  - The RMW states and the merge register are removed.

## Structure
- Package `mem_if_pkg`: state enum `mem_init_state_t`, `WORD_W=32`, `BE_W=4`, `DEFAULT_ADDR_W=30`.
- Sub-module `mem_byte_merge`: combinational lane merge of old word, new word and byte enables. It is instantiated only under `MEM_INIT_RMW_EN`.

## Test plan
- Memory preloaded with word 0 = 0x20082000 and word 0x810 = 0x11. Load byte address 0x2040 → `rsp_valid` at T+3 with `rsp_rdata=0x00000011`. Load 0x0000 → 0x20082000.
- Full store of 0xDEADBEEF at 0x2004, then load 0x2004 → 0xDEADBEEF.
  - `mem_wren` is high exactly one cycle.
  - `mem_rren` is never high together with `mem_wren`.
- With the macro defined, word 0x2000 holds 0x00000040. Store `be=0011`, data 0xAABBCCDD → reload gives 0x0000CCDD.
  - Response at T+4.
- Without the macro, the same store → reload gives 0xAABBCCDD; response at T+2.
- `req_valid` held high for three back-to-back loads → accepts at cycles 0, 3, 6. `rsp_valid` at 3, 6, 9.
- Assert `rst=0` during RMW_MERGE → all strobes low immediately, no `rsp_valid`, memory word unchanged. `req_ready=1` in the first cycle after release.
